// File: rtl/fp_unit_arbiter_if.sv
// fp_unit_arbiter_if: requester, response and FP-unit signals of the shared FP arbiter.
interface fp_unit_arbiter_if #(
  parameter int N   = 3,
  parameter int IDW = 2
);
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    gnt;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic            fpu_sel;
  logic [5:0]      fpu_operation;
  logic            fpu_start;
  logic [31:0]     add_result;
  logic            add_rdy;
  logic [31:0]     mul_result;
  logic            mul_rdy;
  logic            busy;
  modport slave (
    input  req, req_op, req_a, req_b, resp_ready, add_result, add_rdy, mul_result, mul_rdy,
    output gnt, resp_valid, resp_id, resp_data, resp_err, fpu_a, fpu_b, fpu_sel, fpu_operation,
           fpu_start, busy
  );
  modport master (
    output req, req_op, req_a, req_b, resp_ready, add_result, add_rdy, mul_result, mul_rdy,
    input  gnt, resp_valid, resp_id, resp_data, resp_err, fpu_a, fpu_b, fpu_sel, fpu_operation,
           fpu_start, busy
  );
endinterface

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one FP add/sub and one FP multiply unit,
// one operation in flight, id-tagged response and a watchdog on the unit's rdy.
module fp_unit_arbiter #(
  parameter int N       = 3,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  fp_unit_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int TW = $clog2(TIMEOUT);
  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, id_q, id_d, win;
  logic [TW-1:0]  timer_q, timer_d;
  logic [31:0]    a_q, a_d, b_q, b_d, data_q, data_d;
  logic           sel_q, sel_d, sub_q, sub_d, start_q, start_d;
  logic           err_q, err_d, valid_q, valid_d;
  logic           found, rdy;
  logic [1:0]     win_op;
  int             j;
  always_comb begin
    found = 1'b0;
    win = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      j = j >= N ? j - N : j;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win = IDW'(j);
      end
    end
  end
  assign win_op = bus.req_op[2*win +: 2];
  assign rdy = sel_q ? bus.mul_rdy : bus.add_rdy;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    timer_d = timer_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    sel_d = sel_q;
    sub_d = sub_q;
    start_d = 1'b0;
    err_d = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (found) begin
        id_d = win;
        rr_d = (win == IDW'(N-1)) ? '0 : win + 1'b1;
        data_d = '0;
        err_d = &win_op;
        if (&win_op) begin
          state_d = RESP;
          valid_d = 1'b1;
        end else begin
          state_d = ISSUE;
          a_d = bus.req_a[32*win +: 32];
          b_d = bus.req_b[32*win +: 32];
          sel_d = win_op[1];
          sub_d = win_op == 2'b01;
          start_d = 1'b1;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (rdy || timer_q == TW'(TIMEOUT-1)) begin
        // a rdy arriving on the expiry cycle still counts as a good result
        state_d = RESP;
        valid_d = 1'b1;
        err_d = !rdy;
        data_d = !rdy ? 32'h7FC0_0000 : sel_q ? bus.mul_result : bus.add_result;
        a_d = '0;
        b_d = '0;
        sel_d = 1'b0;
        sub_d = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      RESP: if (bus.resp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      timer_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      sel_q <= 1'b0;
      sub_q <= 1'b0;
      start_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      timer_q <= timer_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      sel_q <= sel_d;
      sub_q <= sub_d;
      start_q <= start_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  end
  assign bus.gnt = (state_q == IDLE && found && reset) ? N'(1) << win : '0;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id = id_q;
  assign bus.resp_data = data_q;
  assign bus.resp_err = err_q;
  assign bus.fpu_a = a_q;
  assign bus.fpu_b = b_q;
  assign bus.fpu_sel = sel_q;
  assign bus.fpu_operation = {5'b0, sub_q};
  assign bus.fpu_start = start_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: directed scenario tasks for the shared FP-unit arbiter.
module tb_fp_unit_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  fp_unit_arbiter_if #(.N(3), .IDW(2)) bus ();
  fp_unit_arbiter #(.N(3), .IDW(2), .TIMEOUT(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 3'b111;
    bus.add_rdy = 1'b1;
    cyc(2);
    #1;
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.fpu_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", bus.fpu_start); end
    total++; if (bus.fpu_a !== 32'h0) begin bad++; $display("FAIL reset_fpu_a got=%h exp=0", bus.fpu_a); end
    total++; if (bus.resp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.resp_data); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    bus.req = '0;
    bus.add_rdy = 1'b0;
    reset = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_single_mul();
    cyc();
    set_op(1, 2'b10, 32'h4000_0000, 32'h4040_0000);
    bus.req = 3'b010;
    bus.mul_result = 32'h40C0_0000;
    bus.add_result = 32'hDEAD_BEEF;
    #1;
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL mul_gnt got=%b exp=010", bus.gnt); end
    cyc();
    bus.req = '0;
    #1;
    total++; if (bus.fpu_start !== 1'b1) begin bad++; $display("FAIL mul_start got=%b exp=1", bus.fpu_start); end
    total++; if (bus.fpu_sel !== 1'b1) begin bad++; $display("FAIL mul_sel got=%b exp=1", bus.fpu_sel); end
    total++; if (bus.fpu_a !== 32'h4000_0000) begin bad++; $display("FAIL mul_fpu_a got=%h exp=40000000", bus.fpu_a); end
    total++; if (bus.fpu_b !== 32'h4040_0000) begin bad++; $display("FAIL mul_fpu_b got=%h exp=40400000", bus.fpu_b); end
    cyc();
    #1;
    total++; if (bus.fpu_start !== 1'b0) begin bad++; $display("FAIL mul_start_pulse got=%b exp=0", bus.fpu_start); end
    cyc();
    bus.add_rdy = 1'b1;
    #1;
    cyc();
    bus.add_rdy = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mul_ignore_add_rdy got=%b exp=0", bus.resp_valid); end
    total++; if (bus.fpu_a !== 32'h4000_0000) begin bad++; $display("FAIL mul_fpu_a_stable got=%h exp=40000000", bus.fpu_a); end
    cyc();
    bus.mul_rdy = 1'b1;
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mul_early_valid got=%b exp=0", bus.resp_valid); end
    cyc();
    bus.mul_rdy = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b exp=1", bus.resp_valid); end
    total++; if (bus.resp_id !== 2'd1) begin bad++; $display("FAIL mul_id got=%0d exp=1", bus.resp_id); end
    total++; if (bus.resp_data !== 32'h40C0_0000) begin bad++; $display("FAIL mul_data got=%h exp=40c00000", bus.resp_data); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL mul_err got=%b exp=0", bus.resp_err); end
    total++; if (bus.fpu_a !== 32'h0) begin bad++; $display("FAIL mul_fpu_a_resp got=%h exp=0", bus.fpu_a); end
    total++; if (bus.fpu_sel !== 1'b0) begin bad++; $display("FAIL mul_sel_resp got=%b exp=0", bus.fpu_sel); end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mul_after_hs got=%b exp=0", bus.resp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mul_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    logic [31:0] ea;
    for (int i = 0; i < 3; i++) set_op(i, 2'b00, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i));
    bus.add_result = 32'h4120_0000;
    bus.add_rdy = 1'b1;
    bus.resp_ready = 1'b1;
    cyc();
    bus.req = 3'b111;
    #1;
    for (int g = 0; g < 6; g++) begin
      eg = 3'b001 << (g % 3);
      ea = 32'h3F80_0000 + 32'(g % 3);
      total++; if (bus.gnt !== eg) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", g, bus.gnt, eg); end
      cyc();
      #1;
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rr_issue_gnt%0d got=%b exp=000", g, bus.gnt); end
      total++; if (bus.fpu_a !== ea) begin bad++; $display("FAIL rr_fpu_a%0d got=%h exp=%h", g, bus.fpu_a, ea); end
      cyc();
      #1;
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rr_wait_gnt%0d got=%b exp=000", g, bus.gnt); end
      cyc();
      #1;
      total++; if (bus.resp_id !== 2'(g % 3)) begin bad++; $display("FAIL rr_id%0d got=%0d exp=%0d", g, bus.resp_id, g % 3); end
      total++; if (bus.resp_data !== 32'h4120_0000) begin bad++; $display("FAIL rr_data%0d got=%h exp=41200000", g, bus.resp_data); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL rr_resp_gnt%0d got=%b exp=000", g, bus.gnt); end
      cyc();
      #1;
    end
    bus.req = '0;
    bus.add_rdy = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    cyc();
    set_op(2, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.req = 3'b100;
    #1;
    total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL ill_gnt got=%b exp=100", bus.gnt); end
    cyc();
    bus.req = '0;
    #1;
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b exp=1", bus.resp_valid); end
    total++; if (bus.resp_err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", bus.resp_err); end
    total++; if (bus.resp_data !== 32'h0) begin bad++; $display("FAIL ill_data got=%h exp=0", bus.resp_data); end
    total++; if (bus.resp_id !== 2'd2) begin bad++; $display("FAIL ill_id got=%0d exp=2", bus.resp_id); end
    total++; if (bus.fpu_start !== 1'b0) begin bad++; $display("FAIL ill_start got=%b exp=0", bus.fpu_start); end
    cyc();
    #1;
    total++; if (bus.fpu_start !== 1'b0) begin bad++; $display("FAIL ill_start2 got=%b exp=0", bus.fpu_start); end
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL ill_hold got=%b exp=1", bus.resp_valid); end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL ill_after_hs got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_timeout(input bit late_rdy);
    logic [5:0]  eop;
    logic [31:0] ed;
    eop = late_rdy ? 6'b000000 : 6'b000001;
    ed = late_rdy ? 32'h4049_0FDB : 32'h7FC0_0000;
    cyc();
    set_op(0, late_rdy ? 2'b00 : 2'b01, 32'h3F80_0000, 32'h3F00_0000);
    bus.req = 3'b001;
    bus.add_result = 32'h4049_0FDB;
    #1;
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL to_gnt%0d got=%b exp=001", late_rdy, bus.gnt); end
    cyc();
    bus.req = '0;
    #1;
    total++; if (bus.fpu_start !== 1'b1) begin bad++; $display("FAIL to_start%0d got=%b exp=1", late_rdy, bus.fpu_start); end
    total++; if (bus.fpu_operation !== eop) begin bad++; $display("FAIL to_op%0d got=%b exp=%b", late_rdy, bus.fpu_operation, eop); end
    total++; if (bus.fpu_sel !== 1'b0) begin bad++; $display("FAIL to_sel%0d got=%b exp=0", late_rdy, bus.fpu_sel); end
    for (int i = 0; i < 64; i++) begin
      cyc();
      bus.mul_rdy = i[0];
      bus.add_rdy = late_rdy && i == 63;
      #1;
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL to_wait%0d_%0d got=%b exp=0", late_rdy, i, bus.resp_valid); end
    end
    cyc();
    bus.mul_rdy = 1'b0;
    bus.add_rdy = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL to_valid%0d got=%b exp=1", late_rdy, bus.resp_valid); end
    total++; if (bus.resp_err !== !late_rdy) begin bad++; $display("FAIL to_err%0d got=%b exp=%b", late_rdy, bus.resp_err, !late_rdy); end
    total++; if (bus.resp_data !== ed) begin bad++; $display("FAIL to_data%0d got=%h exp=%h", late_rdy, bus.resp_data, ed); end
    total++; if (bus.resp_id !== 2'd0) begin bad++; $display("FAIL to_id%0d got=%0d exp=0", late_rdy, bus.resp_id); end
    total++; if (bus.fpu_operation !== 6'b0) begin bad++; $display("FAIL to_op_resp%0d got=%b exp=0", late_rdy, bus.fpu_operation); end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy%0d got=%b exp=0", late_rdy, bus.busy); end
  endtask

  task automatic test_backpressure();
    cyc();
    for (int i = 0; i < 3; i++) set_op(i, 2'b00, 32'h4080_0000, 32'h40A0_0000);
    bus.req = 3'b001;
    bus.add_rdy = 1'b1;
    bus.add_result = 32'h4110_0000;
    #1;
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL bp_gnt got=%b exp=001", bus.gnt); end
    cyc();
    bus.req = 3'b110;
    #1;
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL bp_issue_gnt got=%b exp=000", bus.gnt); end
    cyc(2);
    bus.add_result = 32'hFFFF_FFFF;
    #1;
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", i, bus.resp_valid); end
      total++; if (bus.resp_id !== 2'd0) begin bad++; $display("FAIL bp_id%0d got=%0d exp=0", i, bus.resp_id); end
      total++; if (bus.resp_data !== 32'h4110_0000) begin bad++; $display("FAIL bp_data%0d got=%h exp=41100000", i, bus.resp_data); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL bp_gnt%0d got=%b exp=000", i, bus.gnt); end
      if (i == 9) bus.resp_ready = 1'b1;
      cyc();
      bus.resp_ready = 1'b0;
      #1;
    end
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL bp_next_gnt got=%b exp=010", bus.gnt); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs got=%b exp=0", bus.resp_valid); end
    bus.req = '0;
    bus.add_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    cyc();
    set_op(1, 2'b00, 32'h40E0_0000, 32'h3F80_0000);
    bus.req = 3'b010;
    #1;
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL rm_gnt got=%b exp=010", bus.gnt); end
    cyc();
    bus.req = '0;
    cyc(2);
    reset = 1'b0;
    cyc();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.fpu_a !== 32'h0) begin bad++; $display("FAIL rm_fpu_a got=%h exp=0", bus.fpu_a); end
    reset = 1'b1;
    bus.add_rdy = 1'b1;
    bus.add_result = 32'h4100_0000;
    cyc();
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rm_late_rdy got=%b exp=0", bus.resp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy2 got=%b exp=0", bus.busy); end
    bus.req = 3'b110;
    #1;
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL rm_first_gnt got=%b exp=010", bus.gnt); end
    bus.req = '0;
    bus.add_rdy = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b0;
    bus.add_result = '0;
    bus.add_rdy = 1'b0;
    bus.mul_result = '0;
    bus.mul_rdy = 1'b0;
    test_reset();
    test_single_mul();
    do_reset();
    test_round_robin();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
